// File: rtl/siso_pkg.sv
// Shared types and default sizes for the siso_ctrl sequencing controller.
package siso_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } siso_ctrl_state_e;

    localparam int SISO_WIDTH = 8;
    localparam int SISO_DEPTH = 4;

endpackage

// File: rtl/siso_ctrl_shreg.sv
// Loadable left-shift register with serial input and MSB serial output.
module siso_ctrl_shreg
    import siso_pkg::*;
#(
    parameter int WIDTH = SISO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_q,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   w_shifted;

    // One extra bit keeps the shift expression legal for WIDTH == 1.
    assign w_shifted = {r_q, i_sin};

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift) begin
            r_q <= w_shifted[WIDTH-1:0];
        end
    end

    assign o_q   = r_q;
    assign o_msb = r_q[WIDTH-1];

endmodule

// File: rtl/siso_ctrl.sv
// Serialises words into an external siso chain and re-captures them after the
// chain latency, flagging any difference from the transmitted word.
module siso_ctrl
    import siso_pkg::*;
#(
    parameter int WIDTH = SISO_WIDTH,
    parameter int DEPTH = SISO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             abort,
    output logic             si_out,
    input  logic             so_in,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + DEPTH);
    localparam logic [CW-1:0] C_LAST  = CW'(WIDTH + DEPTH - 1);
    localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    siso_ctrl_state_e r_state, w_state_nxt;
    logic [CW-1:0]    r_count, w_count_nxt;
    logic [WIDTH-1:0] r_ref;
    logic             w_accept;
    logic             w_tx_shift;
    logic             w_rx_shift;
    logic             w_tx_msb;
    logic [WIDTH-1:0] w_rx_q;
    logic [WIDTH-1:0] w_unused_tx_q;
    logic             w_unused_rx_msb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_ref   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_accept) begin
                r_ref <= tx_data;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!abort && tx_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                    w_count_nxt = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end else if (r_count == C_LAST) begin
                    w_state_nxt = DONE;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            DONE: begin
                if (abort || rx_ready) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // Capture skips the first DEPTH cycles, so stale chain bits never reach rx.
    assign w_tx_shift = (r_state == RUN) && (r_count < C_WIDTH);
    assign w_rx_shift = (r_state == RUN) && (r_count >= C_DEPTH);

    siso_ctrl_shreg #(.WIDTH(WIDTH)) u_tx_sh (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_accept),
        .i_load_data (tx_data),
        .i_shift     (w_tx_shift),
        .i_sin       (1'b0),
        .o_q         (w_unused_tx_q),
        .o_msb       (w_tx_msb)
    );

    siso_ctrl_shreg #(.WIDTH(WIDTH)) u_rx_sh (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_accept),
        .i_load_data ('0),
        .i_shift     (w_rx_shift),
        .i_sin       (so_in),
        .o_q         (w_rx_q),
        .o_msb       (w_unused_rx_msb)
    );

    assign tx_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign rx_valid = (r_state == DONE);
    assign rx_data  = w_rx_q;
    assign rx_err   = rx_valid && (w_rx_q != r_ref);
    assign si_out   = w_tx_shift ? w_tx_msb : 1'b0;

endmodule

// File: tb/tb_siso_ctrl.sv
// Directed bench for siso_ctrl driving a behavioural siso chain; a second
// instance with a mis-set DEPTH shows the effect of a latency mismatch.
module tb_siso_ctrl;
    import siso_pkg::*;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset, tx_valid, abort, rx_ready, stuck;
    logic [W-1:0] tx_data;
    logic         tx_ready, si_out, so_in, rx_valid, rx_err, busy;
    logic [W-1:0] rx_data;
    logic         tx_ready3, si_out3, so_in3, rx_valid3, rx_err3, busy3;
    logic [W-1:0] rx_data3;
    logic [D-1:0] r_chain, r_chain3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Both chains really have four flops and no reset.
    always_ff @(posedge clk) begin
        r_chain  <= {r_chain[D-2:0], si_out};
        r_chain3 <= {r_chain3[D-2:0], si_out3};
    end
    assign so_in  = stuck ? 1'b0 : r_chain[D-1];
    assign so_in3 = r_chain3[D-1];

    siso_ctrl #(.WIDTH(W), .DEPTH(D)) u_dut (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .abort(abort), .si_out(si_out), .so_in(so_in),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_err(rx_err), .busy(busy)
    );

    siso_ctrl #(.WIDTH(W), .DEPTH(3)) u_dut3 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready3),
        .tx_data(tx_data), .abort(abort), .si_out(si_out3), .so_in(so_in3),
        .rx_valid(rx_valid3), .rx_ready(rx_ready), .rx_data(rx_data3),
        .rx_err(rx_err3), .busy(busy3)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Accepts d, checks the serial stream and exact latency, ends in the DONE cycle.
    task automatic send_word(input logic [W-1:0] d, input logic [W-1:0] exp,
                             input logic exp_err, input string tag);
        logic exp_si;
        tx_data  = d;
        tx_valid = 1'b1;
        if (tx_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_accept tx_ready got %b want 1", tag, tx_ready);
        end
        n_checks++;
        step;
        tx_valid = 1'b0;
        for (int k = 0; k < W + D; k++) begin
            exp_si = (k < W) ? d[W-1-k] : 1'b0;
            if ({busy, rx_valid, si_out} !== {1'b1, 1'b0, exp_si}) begin
                n_errors++;
                $display("FAIL %s_run k=%0d busy/rx_valid/si got %b%b%b want 10%b",
                         tag, k, busy, rx_valid, si_out, exp_si);
            end
            n_checks++;
            step;
        end
        if ({rx_valid, rx_err, rx_data, tx_ready} !== {1'b1, exp_err, exp, 1'b0}) begin
            n_errors++;
            $display("FAIL %s_done valid=%b err=%b data=%h tx_ready=%b want 1 %b %h 0",
                     tag, rx_valid, rx_err, rx_data, tx_ready, exp_err, exp);
        end
        n_checks++;
    endtask

    task automatic check_idle_after(input string tag);
        if ({tx_ready, rx_valid, busy} !== 3'b100) begin
            n_errors++;
            $display("FAIL %s_idle tx_ready/rx_valid/busy got %b%b%b want 100",
                     tag, tx_ready, rx_valid, busy);
        end
        n_checks++;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h33;
        abort    = 1'b0;
        rx_ready = 1'b1;
        stuck    = 1'b0;
        step;
        step;
        if ({busy, tx_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL reset_hold busy/tx_ready got %b%b want 01", busy, tx_ready);
        end
        n_checks++;
        reset    = 1'b0;
        tx_valid = 1'b0;
        step;
        if ({tx_ready, busy, rx_valid, si_out, rx_err, rx_data} !== {5'b10000, 8'h00}) begin
            n_errors++;
            $display("FAIL reset_out tx_ready=%b busy=%b rx_valid=%b si=%b err=%b data=%h want 1 0 0 0 0 00",
                     tx_ready, busy, rx_valid, si_out, rx_err, rx_data);
        end
        n_checks++;
    endtask

    task automatic test_basic;
        rx_ready = 1'b1;
        send_word(8'hA5, 8'hA5, 1'b0, "a5");
        step;
        check_idle_after("a5");
    endtask

    task automatic test_backpressure;
        rx_ready = 1'b0;
        send_word(8'h3C, 8'h3C, 1'b0, "3c");
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) rx_ready = 1'b1;
            if ({rx_valid, rx_err, rx_data, tx_ready, busy} !== {2'b10, 8'h3C, 2'b01}) begin
                n_errors++;
                $display("FAIL hold i=%0d valid=%b err=%b data=%h tx_ready=%b want 1 0 3c 0",
                         i, rx_valid, rx_err, rx_data, tx_ready);
            end
            n_checks++;
            step;
        end
        send_word(8'hFF, 8'hFF, 1'b0, "ff");
        step;
        check_idle_after("ff");
    endtask

    task automatic test_faults;
        reset = 1'b1;
        step;
        step;
        reset    = 1'b0;
        rx_ready = 1'b1;
        stuck    = 1'b1;
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        if ({tx_ready, tx_ready3} !== 2'b11) begin
            n_errors++;
            $display("FAIL fault_accept tx_ready/tx_ready3 got %b%b want 11", tx_ready, tx_ready3);
        end
        n_checks++;
        step;
        tx_valid = 1'b0;
        for (int k = 0; k < W + 3; k++) step;
        if ({rx_valid3, rx_err3, rx_data3, rx_valid} !== {2'b11, 8'h40, 1'b0}) begin
            n_errors++;
            $display("FAIL depth3 valid=%b err=%b data=%h main_valid=%b want 1 1 40 0",
                     rx_valid3, rx_err3, rx_data3, rx_valid);
        end
        n_checks++;
        step;
        if ({rx_valid, rx_err, rx_data} !== {2'b11, 8'h00}) begin
            n_errors++;
            $display("FAIL stuck0 valid=%b err=%b data=%h want 1 1 00", rx_valid, rx_err, rx_data);
        end
        n_checks++;
        stuck = 1'b0;
        step;
        check_idle_after("stuck0");
    endtask

    task automatic test_abort;
        logic [W-1:0] dv;
        dv       = 8'hF0;
        rx_ready = 1'b1;
        tx_data  = dv;
        tx_valid = 1'b1;
        step;
        tx_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (si_out !== dv[W-1-k]) begin
                n_errors++;
                $display("FAIL abort_si k=%0d got %b want %b", k, si_out, dv[W-1-k]);
            end
            n_checks++;
            if (k == 5) abort = 1'b1;
            step;
        end
        abort = 1'b0;
        if ({busy, si_out, rx_valid, tx_ready} !== 4'b0001) begin
            n_errors++;
            $display("FAIL abort_idle busy/si/rx_valid/tx_ready got %b%b%b%b want 0001",
                     busy, si_out, rx_valid, tx_ready);
        end
        n_checks++;
        send_word(8'h0F, 8'h0F, 1'b0, "0f");
        step;
        check_idle_after("0f");
    endtask

    task automatic test_reset_mid;
        for (int ph = 0; ph < 2; ph++) begin
            rx_ready = (ph == 0);
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            step;
            tx_valid = 1'b0;
            for (int k = 0; k < ((ph == 0) ? 9 : W + D); k++) step;
            if (rx_valid !== (ph == 1)) begin
                n_errors++;
                $display("FAIL rst_pre ph=%0d rx_valid got %b want %b", ph, rx_valid, ph == 1);
            end
            n_checks++;
            reset = 1'b1;
            step;
            reset = 1'b0;
            if ({tx_ready, busy, rx_valid, si_out, rx_err, rx_data} !== {5'b10000, 8'h00}) begin
                n_errors++;
                $display("FAIL rst_mid ph=%0d tx_ready=%b busy=%b rx_valid=%b si=%b err=%b data=%h want 1 0 0 0 0 00",
                         ph, tx_ready, busy, rx_valid, si_out, rx_err, rx_data);
            end
            n_checks++;
        end
        rx_ready = 1'b1;
        send_word(8'hAA, 8'hAA, 1'b0, "aa");
        step;
        check_idle_after("aa");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_faults;
        test_abort;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
